// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests, register-file write port and scoreboard signals
interface regfile_wb_arbiter_if #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
);
    logic                alu_req;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_gnt;
    logic                ld_req;
    logic [ADDR_W-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_data;
    logic                ld_gnt;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_addr;
    logic [DATA_W-1:0]   rf_data;
    logic                sb_set;
    logic [ADDR_W-1:0]   sb_addr;
    logic [ADDR_W-1:0]   chk_addr1;
    logic [ADDR_W-1:0]   chk_addr2;
    logic                hazard;
    logic [NUM_REGS-1:0] pending;

    modport master (
        output alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
        output sb_set, sb_addr, chk_addr1, chk_addr2,
        input  alu_gnt, ld_gnt, rf_we, rf_addr, rf_data, hazard, pending
    );

    modport slave (
        input  alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
        input  sb_set, sb_addr, chk_addr1, chk_addr2,
        output alu_gnt, ld_gnt, rf_we, rf_addr, rf_data, hazard, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: ALU/load writeback arbiter with starvation guard and pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 3,
    parameter int NUM_REGS     = 8,
    parameter int STARVE_LIMIT = 3
) (
    input logic clk,
    input logic rst_n,
    regfile_wb_arbiter_if.slave bus
);
    typedef enum logic {LD_PRI, ALU_PRI} state_t;

    localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_starve, w_starve_nxt;
    logic                w_alu_gnt, w_ld_gnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [NUM_REGS-1:0] r_pending, w_set, w_clr;

    // Grants, starvation count and priority state; grants are forced low while in reset
    always_comb begin
        w_alu_gnt    = rst_n && bus.alu_req && (!bus.ld_req || r_state == ALU_PRI);
        w_ld_gnt     = rst_n && bus.ld_req && !w_alu_gnt;
        w_starve_nxt = (!bus.alu_req || w_alu_gnt) ? 3'd0 :
                       (w_ld_gnt && r_starve < LIM) ? r_starve + 3'd1 : r_starve;
        w_state_nxt  = (r_state == LD_PRI && w_starve_nxt == LIM) ? ALU_PRI :
                       (r_state == ALU_PRI && w_alu_gnt) ? LD_PRI : r_state;
    end

    // Arbiter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LD_PRI;
            r_starve <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Registered write port: capture the winner; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_alu_gnt || w_ld_gnt;
            if (w_alu_gnt) begin
                r_addr <= bus.alu_addr;
                r_data <= bus.alu_data;
            end else if (w_ld_gnt) begin
                r_addr <= bus.ld_addr;
                r_data <= bus.ld_data;
            end
        end
    end

    assign w_set = sb_mask(bus.sb_set, bus.sb_addr);
    assign w_clr = sb_mask(r_we, r_addr);

    function automatic logic [NUM_REGS-1:0] sb_mask(input logic en, input logic [ADDR_W-1:0] a);
        sb_mask = en ? (NUM_REGS'(1) << a) : '0;
    endfunction

    // Scoreboard: commit clears, issue sets; a newer issue to the same register wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_clr) | w_set;
    end

    assign bus.alu_gnt = w_alu_gnt;
    assign bus.ld_gnt  = w_ld_gnt;
    assign bus.rf_we   = r_we;
    assign bus.rf_addr = r_addr;
    assign bus.rf_data = r_data;
    assign bus.pending = r_pending;
    assign bus.hazard  = r_pending[bus.chk_addr1] | r_pending[bus.chk_addr2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus, behavioural model and literal checks for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int DW = 8, AW = 3, NR = 8, LIM = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) bus ();

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: ALU is owed the next conflict once it has lost LIM times in a row while requesting
    logic          m_owed;
    int            m_losses;
    logic [NR-1:0] m_pend;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          e_alu, e_ld;

    assign e_alu = rst_n && bus.alu_req && (!bus.ld_req || m_owed);
    assign e_ld  = rst_n && bus.ld_req && !e_alu;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owed   <= 1'b0;
            m_losses <= 0;
            m_pend   <= '0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_data   <= '0;
        end else begin
            if (e_alu) begin
                m_owed   <= 1'b0;
                m_losses <= 0;
            end else if (bus.alu_req) begin
                m_losses <= (m_losses + 1 > LIM) ? LIM : m_losses + 1;
                if (m_losses + 1 >= LIM) m_owed <= 1'b1;
            end else begin
                m_losses <= 0;
            end
            for (int i = 0; i < NR; i++)
                m_pend[i] <= (bus.sb_set && int'(bus.sb_addr) == i) ||
                             (m_pend[i] && !(m_we && int'(m_addr) == i));
            m_we <= e_alu || e_ld;
            if (e_alu) begin
                m_addr <= bus.alu_addr;
                m_data <= bus.alu_data;
            end else if (e_ld) begin
                m_addr <= bus.ld_addr;
                m_data <= bus.ld_data;
            end
        end
    end

    // Compare every cycle, mid-way between rising edges
    always @(negedge clk) begin
        check("m_alu_gnt", bus.alu_gnt, e_alu);
        check("m_ld_gnt", bus.ld_gnt, e_ld);
        check("m_rf_we", bus.rf_we, m_we);
        check("m_rf_addr", bus.rf_addr, m_addr);
        check("m_rf_data", bus.rf_data, m_data);
        check("m_pending", bus.pending, m_pend);
        check("m_hazard", bus.hazard, m_pend[bus.chk_addr1] | m_pend[bus.chk_addr2]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] apat, lpat;

    initial begin
        bus.alu_req = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.ld_req = 0;  bus.ld_addr = 0;  bus.ld_data = 0;
        bus.sb_set = 0;  bus.sb_addr = 0;
        bus.chk_addr1 = 0; bus.chk_addr2 = 0;
        tick();
        tick();
        check("reset_rf_we", bus.rf_we, 0);
        check("reset_pending", bus.pending, 0);
        rst_n = 1'b1;

        // Lone ALU request
        tick();
        bus.alu_req = 1; bus.alu_addr = 3'd5; bus.alu_data = 8'hA7;
        #1;
        check("lone_alu_gnt", bus.alu_gnt, 1);
        check("lone_ld_gnt", bus.ld_gnt, 0);
        tick();
        bus.alu_req = 0;
        check("lone_rf_we", bus.rf_we, 1);
        check("lone_rf_addr", bus.rf_addr, 5);
        check("lone_rf_data", bus.rf_data, 8'hA7);
        tick();
        check("lone_rf_we_off", bus.rf_we, 0);
        check("lone_rf_addr_hold", bus.rf_addr, 5);

        // Continuous conflict: ld,ld,ld,alu repeating
        bus.alu_req = 1; bus.alu_addr = 3'd0; bus.alu_data = 8'h11;
        bus.ld_req = 1;  bus.ld_addr = 3'd7;  bus.ld_data = 8'h22;
        for (int k = 0; k < 8; k++) begin
            #1;
            apat[k] = bus.alu_gnt;
            lpat[k] = bus.ld_gnt;
            tick();
        end
        bus.alu_req = 0; bus.ld_req = 0;
        check("conflict_alu_pattern", apat, 8'b1000_1000);
        check("conflict_ld_pattern", lpat, 8'b0111_0111);
        tick();

        // Scoreboard set then cleared by load commit
        bus.sb_set = 1; bus.sb_addr = 3'd2; bus.chk_addr1 = 3'd2; bus.chk_addr2 = 3'd0;
        #1;
        check("sb_hazard_before_edge", bus.hazard, 0);
        tick();
        bus.sb_set = 0;
        check("sb_hazard_set", bus.hazard, 1);
        check("sb_pending_set", bus.pending, 8'h04);
        tick();
        check("sb_hazard_held", bus.hazard, 1);
        bus.ld_req = 1; bus.ld_addr = 3'd2; bus.ld_data = 8'h3C;
        #1;
        check("sb_ld_gnt", bus.ld_gnt, 1);
        tick();
        bus.ld_req = 0;
        check("sb_commit_we", bus.rf_we, 1);
        check("sb_commit_addr", bus.rf_addr, 2);
        check("sb_no_bypass", bus.hazard, 1);
        tick();
        check("sb_hazard_cleared", bus.hazard, 0);
        check("sb_pending_cleared", bus.pending, 0);

        // Simultaneous set and clear of reg 4
        bus.sb_set = 1; bus.sb_addr = 3'd4;
        tick();
        bus.sb_set = 0;
        bus.ld_req = 1; bus.ld_addr = 3'd4; bus.ld_data = 8'h55;
        tick();
        bus.ld_req = 0;
        check("setclr_commit_we", bus.rf_we, 1);
        bus.sb_set = 1; bus.sb_addr = 3'd4;
        tick();
        bus.sb_set = 0;
        check("setclr_pending", bus.pending, 8'h10);

        // Back-to-back alternating writes
        bus.alu_req = 1; bus.alu_addr = 3'd1; bus.alu_data = 8'h01;
        tick();
        bus.alu_req = 0;
        bus.ld_req = 1; bus.ld_addr = 3'd3; bus.ld_data = 8'h33;
        check("b2b_we1", bus.rf_we, 1);
        check("b2b_addr1", bus.rf_addr, 1);
        check("b2b_data1", bus.rf_data, 8'h01);
        tick();
        bus.ld_req = 0;
        bus.alu_req = 1; bus.alu_addr = 3'd6; bus.alu_data = 8'h66;
        check("b2b_we2", bus.rf_we, 1);
        check("b2b_addr2", bus.rf_addr, 3);
        check("b2b_data2", bus.rf_data, 8'h33);
        tick();
        bus.alu_req = 0;
        check("b2b_we3", bus.rf_we, 1);
        check("b2b_addr3", bus.rf_addr, 6);
        check("b2b_data3", bus.rf_data, 8'h66);
        tick();

        // Asynchronous reset while a write is in flight
        bus.alu_req = 1; bus.alu_addr = 3'd7; bus.alu_data = 8'h77;
        bus.sb_set = 1; bus.sb_addr = 3'd1;
        tick();
        bus.alu_req = 0; bus.sb_set = 0;
        check("rst_pre_we", bus.rf_we, 1);
        check("rst_pre_pending", bus.pending, 8'h12);
        #2;
        bus.alu_req = 1;
        rst_n = 1'b0;
        #1;
        check("rst_async_we", bus.rf_we, 0);
        check("rst_async_pending", bus.pending, 0);
        check("rst_async_gnt", bus.alu_gnt, 0);
        check("rst_async_addr", bus.rf_addr, 0);
        tick();
        bus.alu_req = 0;
        rst_n = 1'b1;
        tick();
        check("rst_post_we", bus.rf_we, 0);
        check("rst_post_pending", bus.pending, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
